bwt_occ_fetch: RTL

Occurrence-fetch responder for the backward SMEM pipeline. Accepts the per-step memory requests (`request_valid`, `addr_k`, `addr_l`, plus opaque context) emitted by the backward data path. It fetches the two 512-bit BWT occurrence cachelines from external memory and returns the unpacked `cnt_*`/`cntl_*` fields with the matching context, in request order. It sits between the backward control stage and the memory port, closing the k/l lookup loop.

---
 rtl/bwt_occ_fetch.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bwt_occ_fetch.sv
// Occurrence-fetch responder: queues k/l lookups, reads both BWT occurrence lines, returns unpacked counts in order.
// Optional BWT_SAME_LINE_EN: a request whose k and l lines coincide issues a single read and reuses the line.
module bwt_occ_fetch #(
  parameter int ADDR_W = 42,
  parameter int CTX_W  = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              request_valid,
  input  logic [ADDR_W-1:0] addr_k,
  input  logic [ADDR_W-1:0] addr_l,
  input  logic [CTX_W-1:0]  req_ctx,
  output logic              req_full,
  output logic              err_overflow,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [511:0]      mem_rsp_data,
  output logic              mem_rsp_ready,
  output logic              rsp_valid,
  output logic [CTX_W-1:0]  rsp_ctx,
  output logic [31:0]       cnt_a0,
  output logic [31:0]       cnt_a1,
  output logic [31:0]       cnt_a2,
  output logic [31:0]       cnt_a3,
  output logic [63:0]       cnt_b0,
  output logic [63:0]       cnt_b1,
  output logic [63:0]       cnt_b2,
  output logic [63:0]       cnt_b3,
  output logic [31:0]       cntl_a0,
  output logic [31:0]       cntl_a1,
  output logic [31:0]       cntl_a2,
  output logic [31:0]       cntl_a3,
  output logic [63:0]       cntl_b0,
  output logic [63:0]       cntl_b1,
  output logic [63:0]       cntl_b2,
  output logic [63:0]       cntl_b3
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = 384;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  localparam logic [1:0] ISS_IDLE = 2'd0;
  localparam logic [1:0] ISS_K    = 2'd1;
  localparam logic [1:0] ISS_L    = 2'd2;

  localparam logic [1:0] COL_K    = 2'd0;
  localparam logic [1:0] COL_L    = 2'd1;
  localparam logic [1:0] COL_OUT  = 2'd2;

  logic [ADDR_W-1:0] rq_addr_k [DEPTH];
  logic [ADDR_W-1:0] rq_addr_l [DEPTH];
  logic [CTX_W-1:0]  rq_ctx    [DEPTH];
  logic              rq_single [DEPTH];
  logic [PTR_W-1:0]  rq_wr_q, rq_rd_q;
  logic [CNT_W-1:0]  rq_cnt_q;

  logic [CTX_W-1:0]  pd_ctx    [DEPTH];
  logic              pd_single [DEPTH];
  logic [PTR_W-1:0]  pd_wr_q, pd_rd_q;
  logic [CNT_W-1:0]  pd_cnt_q;

  logic [1:0]        iss_q, iss_d;
  logic [1:0]        col_q, col_d;
  logic [LINE_W-1:0] k_line_q, k_line_d, l_line_q, l_line_d;
  logic [LINE_W-1:0] out_k_q, out_k_d, out_l_q, out_l_d;
  logic [CTX_W-1:0]  rsp_ctx_q, rsp_ctx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;

  logic              req_single, rq_push, rq_pop, pd_push, pd_pop;
  logic              mem_req_fire, mem_rsp_fire, head_single, out_hold;
  logic              chain_ok, col_ready;
  logic              unused_rsp_hi;

`ifdef BWT_SAME_LINE_EN
  assign req_single = (addr_k == addr_l);
`else
  assign req_single = 1'b0;
`endif

  assign req_full     = (rq_cnt_q == FULL_CNT);
  assign rq_push      = request_valid && !req_full;
  assign err_d        = err_q || (request_valid && req_full);

  assign mem_req_valid = (iss_q == ISS_K) || (iss_q == ISS_L);
  assign mem_req_addr  = (iss_q == ISS_K) ? rq_addr_k[rq_rd_q] :
                         (iss_q == ISS_L) ? rq_addr_l[rq_rd_q] : '0;
  assign mem_req_fire  = mem_req_valid && mem_req_ready;

  // Chain straight into the next queued entry so back-to-back requests issue every two cycles.
  assign chain_ok = ((rq_cnt_q > ONE_CNT) || rq_push) && (pd_cnt_q < LAST_CNT);

  always_comb begin
    iss_d   = iss_q;
    rq_pop  = 1'b0;
    pd_push = 1'b0;
    case (iss_q)
      ISS_IDLE: begin
        if (((rq_cnt_q != '0) || rq_push) && (pd_cnt_q != FULL_CNT)) iss_d = ISS_K;
      end
      ISS_K: begin
        if (mem_req_fire) begin
          if (rq_single[rq_rd_q]) begin
            rq_pop  = 1'b1;
            pd_push = 1'b1;
            iss_d   = chain_ok ? ISS_K : ISS_IDLE;
          end else begin
            iss_d = ISS_L;
          end
        end
      end
      ISS_L: begin
        if (mem_req_fire) begin
          rq_pop  = 1'b1;
          pd_push = 1'b1;
          iss_d   = chain_ok ? ISS_K : ISS_IDLE;
        end
      end
      default: iss_d = ISS_IDLE;
    endcase
  end

  // A k line can only be in flight once a read has been issued; while the pending queue is still
  // empty that read belongs to the entry sitting in ISS_L, which is never single.
  assign out_hold      = rsp_valid_q && stall;
  assign head_single   = (pd_cnt_q != '0) && pd_single[pd_rd_q];
  assign col_ready     = !out_hold &&
                         (((col_q == COL_K) && ((pd_cnt_q != '0) || (iss_q == ISS_L))) ||
                          (col_q == COL_L));
  assign mem_rsp_ready = col_ready;
  assign mem_rsp_fire  = mem_rsp_valid && col_ready;
  assign unused_rsp_hi = ^mem_rsp_data[511:LINE_W];

  always_comb begin
    col_d       = col_q;
    pd_pop      = 1'b0;
    k_line_d    = k_line_q;
    l_line_d    = l_line_q;
    out_k_d     = out_k_q;
    out_l_d     = out_l_q;
    rsp_ctx_d   = rsp_ctx_q;
    rsp_valid_d = out_hold;
    case (col_q)
      COL_K: begin
        if (mem_rsp_fire) begin
          k_line_d = mem_rsp_data[LINE_W-1:0];
          if (head_single) begin
            l_line_d = mem_rsp_data[LINE_W-1:0];
            col_d    = COL_OUT;
          end else begin
            col_d = COL_L;
          end
        end
      end
      COL_L: begin
        if (mem_rsp_fire) begin
          l_line_d = mem_rsp_data[LINE_W-1:0];
          col_d    = COL_OUT;
        end
      end
      COL_OUT: begin
        if (!out_hold) begin
          out_k_d     = k_line_q;
          out_l_d     = l_line_q;
          rsp_ctx_d   = pd_ctx[pd_rd_q];
          rsp_valid_d = 1'b1;
          pd_pop      = 1'b1;
          col_d       = COL_K;
        end
      end
      default: col_d = COL_K;
    endcase
  end

  // NOTE: queue storage and line buffers carry no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_addr_k[rq_wr_q] <= addr_k;
      rq_addr_l[rq_wr_q] <= addr_l;
      rq_ctx[rq_wr_q]    <= req_ctx;
      rq_single[rq_wr_q] <= req_single;
    end
    if (pd_push) begin
      pd_ctx[pd_wr_q]    <= rq_ctx[rq_rd_q];
      pd_single[pd_wr_q] <= rq_single[rq_rd_q];
    end
    k_line_q <= k_line_d;
    l_line_q <= l_line_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rq_wr_q     <= '0;
      rq_rd_q     <= '0;
      rq_cnt_q    <= '0;
      pd_wr_q     <= '0;
      pd_rd_q     <= '0;
      pd_cnt_q    <= '0;
      iss_q       <= ISS_IDLE;
      col_q       <= COL_K;
      out_k_q     <= '0;
      out_l_q     <= '0;
      rsp_ctx_q   <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (rq_push) rq_wr_q <= rq_wr_q + 1'b1;
      if (rq_pop)  rq_rd_q <= rq_rd_q + 1'b1;
      case ({rq_push, rq_pop})
        2'b10:   rq_cnt_q <= rq_cnt_q + 1'b1;
        2'b01:   rq_cnt_q <= rq_cnt_q - 1'b1;
        default: rq_cnt_q <= rq_cnt_q;
      endcase
      if (pd_push) pd_wr_q <= pd_wr_q + 1'b1;
      if (pd_pop)  pd_rd_q <= pd_rd_q + 1'b1;
      case ({pd_push, pd_pop})
        2'b10:   pd_cnt_q <= pd_cnt_q + 1'b1;
        2'b01:   pd_cnt_q <= pd_cnt_q - 1'b1;
        default: pd_cnt_q <= pd_cnt_q;
      endcase
      iss_q       <= iss_d;
      col_q       <= col_d;
      out_k_q     <= out_k_d;
      out_l_q     <= out_l_d;
      rsp_ctx_q   <= rsp_ctx_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign err_overflow = err_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_ctx      = rsp_ctx_q;

  assign cnt_a0  = out_k_q[31:0];
  assign cnt_a1  = out_k_q[63:32];
  assign cnt_a2  = out_k_q[95:64];
  assign cnt_a3  = out_k_q[127:96];
  assign cnt_b0  = out_k_q[191:128];
  assign cnt_b1  = out_k_q[255:192];
  assign cnt_b2  = out_k_q[319:256];
  assign cnt_b3  = out_k_q[383:320];

  assign cntl_a0 = out_l_q[31:0];
  assign cntl_a1 = out_l_q[63:32];
  assign cntl_a2 = out_l_q[95:64];
  assign cntl_a3 = out_l_q[127:96];
  assign cntl_b0 = out_l_q[191:128];
  assign cntl_b1 = out_l_q[255:192];
  assign cntl_b2 = out_l_q[319:256];
  assign cntl_b3 = out_l_q[383:320];

endmodule
